// File: rtl/issue_select_sched.sv
// Collapsing issue queue: entry 0 is oldest, oldest-ready select, one registered issue per cycle.
// Tags wake from writeback broadcasts and, optionally, from last cycle's fired destination.
module issue_select_sched #(
    parameter int IQ_DEPTH  = 8,
    parameter int PREG_W    = 6,
    parameter int PAY_W     = 96,
    parameter int NUM_WB    = 2,
    parameter bit SPEC_WAKE = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [PREG_W-1:0]            disp_src1_preg,
    input  logic                         disp_src1_rdy,
    input  logic [PREG_W-1:0]            disp_src2_preg,
    input  logic                         disp_src2_rdy,
    input  logic [PREG_W-1:0]            disp_dst_preg,
    input  logic                         disp_dst_vld,
    input  logic [PAY_W-1:0]             disp_payload,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*PREG_W-1:0]     wb_preg,
    input  logic                         exec_stall,
    input  logic                         flush,
    output logic                         fire_valid,
    output logic [PREG_W-1:0]            fire_src1_preg,
    output logic [PREG_W-1:0]            fire_src2_preg,
    output logic [PREG_W-1:0]            fire_dst_preg,
    output logic [PAY_W-1:0]             fire_payload,
    output logic [$clog2(IQ_DEPTH):0]    iq_count
);
    localparam int IW = $clog2(IQ_DEPTH);
    localparam int CW = IW + 1;

    logic [PREG_W-1:0] e_src1 [IQ_DEPTH];
    logic [PREG_W-1:0] e_src2 [IQ_DEPTH];
    logic [PREG_W-1:0] e_dst  [IQ_DEPTH];
    logic [PAY_W-1:0]  e_pay  [IQ_DEPTH];
    logic              e_rdy1 [IQ_DEPTH];
    logic              e_rdy2 [IQ_DEPTH];
    logic              e_dvld [IQ_DEPTH];

    logic [PREG_W-1:0] n_src1 [IQ_DEPTH];
    logic [PREG_W-1:0] n_src2 [IQ_DEPTH];
    logic [PREG_W-1:0] n_dst  [IQ_DEPTH];
    logic [PAY_W-1:0]  n_pay  [IQ_DEPTH];
    logic              n_rdy1 [IQ_DEPTH];
    logic              n_rdy2 [IQ_DEPTH];
    logic              n_dvld [IQ_DEPTH];

    logic              w_rdy1 [IQ_DEPTH];
    logic              w_rdy2 [IQ_DEPTH];
    logic              d_rdy1, d_rdy2;

    logic [CW-1:0]     count_q, cnt_after;
    logic              fire_dvld_q;
    logic              spec_v;
    logic              found, issue, accept;
    logic [IW-1:0]     sel;

    // A fired op without a destination must not wake anything.
    assign spec_v = SPEC_WAKE && fire_valid && fire_dvld_q;

    function automatic logic hit(input logic [PREG_W-1:0]        tag,
                                 input logic [NUM_WB-1:0]        v,
                                 input logic [NUM_WB*PREG_W-1:0] p,
                                 input logic                     sv,
                                 input logic [PREG_W-1:0]        sp);
        hit = sv && (sp == tag);
        for (int j = 0; j < NUM_WB; j++)
            if (v[j] && (p[j*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            w_rdy1[i] = e_rdy1[i] | hit(e_src1[i], wb_valid, wb_preg, spec_v, fire_dst_preg);
            w_rdy2[i] = e_rdy2[i] | hit(e_src2[i], wb_valid, wb_preg, spec_v, fire_dst_preg);
        end
        d_rdy1 = disp_src1_rdy | hit(disp_src1_preg, wb_valid, wb_preg, spec_v, fire_dst_preg);
        d_rdy2 = disp_src2_rdy | hit(disp_src2_preg, wb_valid, wb_preg, spec_v, fire_dst_preg);
    end

    // Select sees stored readiness only; this cycle's wakeups count next cycle.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < IQ_DEPTH; i++)
            if (!found && (i < int'(count_q)) && e_rdy1[i] && e_rdy2[i]) begin
                found = 1'b1;
                sel   = IW'(i);
            end
    end

    assign disp_ready = (count_q < CW'(IQ_DEPTH)) & ~flush;
    assign accept     = disp_valid & disp_ready;
    assign issue      = found & ~exec_stall & ~flush;
    assign cnt_after  = count_q - CW'(issue);
    assign iq_count   = count_q;

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            logic sh;
            int   k;
            sh = issue && (i >= int'(sel)) && (i < IQ_DEPTH-1);
            k  = sh ? i + 1 : i;
            n_src1[i] = e_src1[k];
            n_src2[i] = e_src2[k];
            n_dst[i]  = e_dst[k];
            n_pay[i]  = e_pay[k];
            n_dvld[i] = e_dvld[k];
            n_rdy1[i] = w_rdy1[k];
            n_rdy2[i] = w_rdy2[k];
            if (accept && (i == int'(cnt_after))) begin
                n_src1[i] = disp_src1_preg;
                n_src2[i] = disp_src2_preg;
                n_dst[i]  = disp_dst_preg;
                n_pay[i]  = disp_payload;
                n_dvld[i] = disp_dst_vld;
                n_rdy1[i] = d_rdy1;
                n_rdy2[i] = d_rdy2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q        <= '0;
            fire_valid     <= 1'b0;
            fire_dvld_q    <= 1'b0;
            fire_src1_preg <= '0;
            fire_src2_preg <= '0;
            fire_dst_preg  <= '0;
            fire_payload   <= '0;
        end else begin
            fire_valid <= issue;
            if (issue) begin
                fire_src1_preg <= e_src1[sel];
                fire_src2_preg <= e_src2[sel];
                fire_dst_preg  <= e_dst[sel];
                fire_payload   <= e_pay[sel];
                fire_dvld_q    <= e_dvld[sel];
            end
            count_q <= flush ? '0 : cnt_after + CW'(accept);
        end
    end

    // Slots at or above count_q are dead, so the payload array needs no reset.
    always_ff @(posedge clk) begin
        e_src1 <= n_src1;
        e_src2 <= n_src2;
        e_dst  <= n_dst;
        e_pay  <= n_pay;
        e_dvld <= n_dvld;
        e_rdy1 <= n_rdy1;
        e_rdy2 <= n_rdy2;
    end
endmodule

// File: tb/tb_issue_select_sched.sv
// Directed bench for issue_select_sched: expected issue packets are queued when driven, popped on fire.
module tb_issue_select_sched;
    logic        clk, rst;
    logic        disp_valid, disp_ready;
    logic [5:0]  disp_src1_preg, disp_src2_preg, disp_dst_preg;
    logic        disp_src1_rdy, disp_src2_rdy, disp_dst_vld;
    logic [95:0] disp_payload;
    logic [1:0]  wb_valid;
    logic [11:0] wb_preg;
    logic        exec_stall, flush;
    logic        fire_valid;
    logic [5:0]  fire_src1_preg, fire_src2_preg, fire_dst_preg;
    logic [95:0] fire_payload;
    logic [3:0]  iq_count;

    typedef struct {
        logic [5:0]  src1;
        logic [5:0]  dst;
        logic [95:0] pay;
    } exp_t;
    exp_t sbq[$];

    int checks   = 0;
    int failures = 0;

    issue_select_sched dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1_preg(disp_src1_preg), .disp_src1_rdy(disp_src1_rdy),
        .disp_src2_preg(disp_src2_preg), .disp_src2_rdy(disp_src2_rdy),
        .disp_dst_preg(disp_dst_preg), .disp_dst_vld(disp_dst_vld),
        .disp_payload(disp_payload),
        .wb_valid(wb_valid), .wb_preg(wb_preg),
        .exec_stall(exec_stall), .flush(flush),
        .fire_valid(fire_valid), .fire_src1_preg(fire_src1_preg),
        .fire_src2_preg(fire_src2_preg), .fire_dst_preg(fire_dst_preg),
        .fire_payload(fire_payload), .iq_count(iq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1ns after the edge and any fire is scored.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (fire_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_fire", 128'(fire_valid), 128'(1'b0));
            end else begin
                e = sbq.pop_front();
                chk("sb_fire_dst", 128'(fire_dst_preg), 128'(e.dst));
                chk("sb_fire_src1", 128'(fire_src1_preg), 128'(e.src1));
                chk("sb_fire_payload", 128'(fire_payload), 128'(e.pay));
            end
        end
    endtask

    task automatic idle();
        disp_valid = 1'b0; disp_src1_preg = '0; disp_src1_rdy = 1'b0;
        disp_src2_preg = '0; disp_src2_rdy = 1'b0; disp_dst_preg = '0;
        disp_dst_vld = 1'b0; disp_payload = '0; wb_valid = '0; wb_preg = '0;
        exec_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic set_disp(input int s1, input bit r1, input int s2, input bit r2,
                            input int d, input int p);
        disp_valid = 1'b1;
        disp_src1_preg = 6'(s1); disp_src1_rdy = r1;
        disp_src2_preg = 6'(s2); disp_src2_rdy = r2;
        disp_dst_preg = 6'(d); disp_dst_vld = 1'b1;
        disp_payload = 96'(p);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", 128'(iq_count), 128'(0));
        chk("rst_fire_valid", 128'(fire_valid), 128'(0));
        chk("rst_fire_dst", 128'(fire_dst_preg), 128'(0));
        chk("rst_fire_payload", 128'(fire_payload), 128'(0));
        chk("rst_disp_ready", 128'(disp_ready), 128'(1));

        // Ready-at-dispatch op: stored first, fires one cycle after acceptance.
        sbq.push_back('{src1: 6'd1, dst: 6'd5, pay: 96'd1});
        set_disp(1, 1, 2, 1, 5, 1);
        tick();
        disp_valid = 1'b0;
        chk("t1_count_after_accept", 128'(iq_count), 128'(1));
        chk("t1_no_fire_on_accept", 128'(fire_valid), 128'(0));
        tick();
        chk("t1_fire_valid", 128'(fire_valid), 128'(1));
        chk("t1_fire_dst", 128'(fire_dst_preg), 128'(5));
        chk("t1_count_drained", 128'(iq_count), 128'(0));
        tick();
        chk("t1_fire_drops", 128'(fire_valid), 128'(0));

        // Younger ready op bypasses an older waiting one; wb port 0 wakes the older.
        sbq.push_back('{src1: 6'd3, dst: 6'd11, pay: 96'd3});
        sbq.push_back('{src1: 6'd7, dst: 6'd10, pay: 96'd2});
        set_disp(7, 0, 8, 1, 10, 2);
        tick();
        set_disp(3, 1, 4, 1, 11, 3);
        tick();
        disp_valid = 1'b0;
        chk("t2_count", 128'(iq_count), 128'(2));
        chk("t2_no_fire_yet", 128'(fire_valid), 128'(0));
        tick();
        chk("t2_b_fires", 128'(fire_valid), 128'(1));
        chk("t2_count_one", 128'(iq_count), 128'(1));
        wb_valid = 2'b01; wb_preg = {6'd0, 6'd7};
        tick();
        wb_valid = 2'b00;
        chk("t2_wake_cycle_no_fire", 128'(fire_valid), 128'(0));
        tick();
        chk("t2_a_fires", 128'(fire_valid), 128'(1));
        chk("t2_a_dst", 128'(fire_dst_preg), 128'(10));

        // Speculative wake from the fired destination, with dispatch landing during an issue.
        sbq.push_back('{src1: 6'd1, dst: 6'd9, pay: 96'd4});
        sbq.push_back('{src1: 6'd9, dst: 6'd12, pay: 96'd5});
        set_disp(1, 1, 2, 1, 9, 4);
        tick();
        set_disp(9, 0, 3, 1, 12, 5);
        tick();
        disp_valid = 1'b0;
        chk("t3_a_fires", 128'(fire_valid), 128'(1));
        chk("t3_count_disp_plus_issue", 128'(iq_count), 128'(1));
        tick();
        chk("t3_b_waking", 128'(fire_valid), 128'(0));
        tick();
        chk("t3_b_fires", 128'(fire_valid), 128'(1));
        chk("t3_b_dst", 128'(fire_dst_preg), 128'(12));

        // Fill with waiting ops; a full queue refuses dispatch until an issue frees a slot.
        for (int i = 0; i < 8; i++) begin
            set_disp(20 + i, 0, 2, 1, 40 + i, 100 + i);
            tick();
        end
        chk("t4_full_count", 128'(iq_count), 128'(8));
        chk("t4_full_not_ready", 128'(disp_ready), 128'(0));
        set_disp(1, 1, 2, 1, 60, 999);
        tick();
        disp_valid = 1'b0;
        chk("t4_full_drop_count", 128'(iq_count), 128'(8));
        sbq.push_back('{src1: 6'd23, dst: 6'd43, pay: 96'd103});
        wb_valid = 2'b10; wb_preg = {6'd23, 6'd0};
        tick();
        wb_valid = 2'b00;
        chk("t4_still_full", 128'(disp_ready), 128'(0));
        tick();
        chk("t4_mid_fire_dst", 128'(fire_dst_preg), 128'(43));
        chk("t4_count_seven", 128'(iq_count), 128'(7));
        chk("t4_ready_again", 128'(disp_ready), 128'(1));
        for (int i = 0; i < 8; i++)
            if (i != 3) sbq.push_back('{src1: 6'(20 + i), dst: 6'(40 + i), pay: 96'(100 + i)});
        wb_valid = 2'b11; wb_preg = {6'd21, 6'd20}; tick();
        wb_preg = {6'd24, 6'd22}; tick();
        wb_preg = {6'd26, 6'd25}; tick();
        wb_valid = 2'b01; wb_preg = {6'd0, 6'd27}; tick();
        wb_valid = 2'b00;
        repeat (8) tick();
        chk("t4_drained", 128'(iq_count), 128'(0));
        chk("t4_sb_empty", 128'(sbq.size()), 128'(0));

        // exec_stall holds ready ops without losing any; release issues oldest first.
        exec_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_disp(1, 1, 2, 1, 50 + k, 200 + k);
            tick();
            chk("t5_stall_no_fire_disp", 128'(fire_valid), 128'(0));
        end
        disp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_stall_no_fire", 128'(fire_valid), 128'(0));
        end
        chk("t5_stall_count", 128'(iq_count), 128'(3));
        for (int k = 0; k < 3; k++)
            sbq.push_back('{src1: 6'd1, dst: 6'(50 + k), pay: 96'(200 + k)});
        exec_stall = 1'b0;
        tick();
        chk("t5_release_oldest", 128'(fire_dst_preg), 128'(50));
        tick(); tick();
        chk("t5_drained", 128'(iq_count), 128'(0));

        // Flush beats a simultaneous dispatch and wipes the queue.
        for (int i = 0; i < 5; i++) begin
            set_disp(30, 0, 2, 1, 70 + i, 300 + i);
            tick();
        end
        chk("t6_count_five", 128'(iq_count), 128'(5));
        set_disp(1, 1, 2, 1, 77, 307);
        flush = 1'b1;
        #1;
        chk("t6_flush_blocks_ready", 128'(disp_ready), 128'(0));
        tick();
        flush = 1'b0; disp_valid = 1'b0;
        chk("t6_flush_count", 128'(iq_count), 128'(0));
        chk("t6_flush_fire", 128'(fire_valid), 128'(0));
        wb_valid = 2'b01; wb_preg = {6'd0, 6'd30};
        tick();
        wb_valid = 2'b00;
        tick(); tick();
        chk("t6_no_ghost_entries", 128'(iq_count), 128'(0));

        // Reset mid-operation clears an in-flight fire and pending entries.
        sbq.push_back('{src1: 6'd1, dst: 6'd60, pay: 96'd400});
        set_disp(1, 1, 2, 1, 60, 400);
        tick();
        set_disp(1, 1, 2, 1, 61, 401);
        tick();
        disp_valid = 1'b0;
        chk("t7_fire_before_rst", 128'(fire_valid), 128'(1));
        rst = 1'b1;
        tick();
        chk("t7_rst_fire_valid", 128'(fire_valid), 128'(0));
        chk("t7_rst_count", 128'(iq_count), 128'(0));
        chk("t7_rst_fire_dst", 128'(fire_dst_preg), 128'(0));
        rst = 1'b0;
        tick(); tick();
        chk("t7_post_rst_count", 128'(iq_count), 128'(0));
        chk("end_sb_empty", 128'(sbq.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
